// File: rtl/ir_queue.sv
// ----------------------------------------------------------------------------
// ir_queue
// Instruction register fed by a small prefetch FIFO. Fetch pushes words into a
// DEPTH-entry circular buffer; a load request moves the oldest word into the
// instruction register, whose contents and decoded address/immediate fields
// are presented to the decoder. A flush empties the queue and invalidates the
// IR without disturbing the last IR value.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst_n          synchronous active-low reset
//   ins_valid_in   fetch offers ins_in
//   ins_in         fetched instruction word
//   ins_ready_out  queue not full (push = ins_valid_in && ins_ready_out)
//   il_in          load queue head into IR
//   flush_in       discard queue and invalidate IR (highest priority)
//   ins_out        IR contents
//   ia_out         address field, zero-extended
//   iv_out         immediate field, zero- or sign-extended per SIGN_EXT
//   ir_valid_out   IR holds a loaded, unflushed instruction
//   level_out      queue occupancy 0..DEPTH
//   uflow_out      one-cycle pulse after a load request on an empty queue
// ----------------------------------------------------------------------------
module ir_queue #(
  parameter int W        = 16,
  parameter int DEPTH    = 4,
  parameter int AF_BITS  = 8,
  parameter int IF_BITS  = 8,
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ins_valid_in,
  input  logic [W-1:0]                 ins_in,
  output logic                         ins_ready_out,
  input  logic                         il_in,
  input  logic                         flush_in,
  output logic [W-1:0]                 ins_out,
  output logic [W-1:0]                 ia_out,
  output logic [W-1:0]                 iv_out,
  output logic                         ir_valid_out,
  output logic [$clog2(DEPTH+1)-1:0]   level_out,
  output logic                         uflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [LW-1:0] count_q, count_d;
  logic [W-1:0]  ir_q, ir_d;
  logic          irValid_q, irValid_d;
  logic          uflow_q, uflow_d;

  logic push;
  logic loadOk;

  // Ready depends only on the registered count, so a load in the same cycle
  // never opens a slot for a push into a full queue.
  assign ins_ready_out = (count_q != LW'(DEPTH));
  assign push          = ins_valid_in && ins_ready_out;
  assign loadOk        = il_in && (count_q != '0);

  // Next-state logic: flush overrides everything; otherwise push and load
  // act independently. An empty queue never bypasses a same-cycle push into
  // the IR; that case reports underflow instead.
  always_comb begin
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    count_d   = count_q;
    ir_d      = ir_q;
    irValid_d = irValid_q;
    uflow_d   = 1'b0;
    if (flush_in) begin
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
      irValid_d = 1'b0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (loadOk) begin
        ir_d      = mem_q[rdPtr_q];
        rdPtr_d   = rdPtr_q + 1'b1;
        irValid_d = 1'b1;
      end
      uflow_d = il_in && (count_q == '0);
      count_d = count_q + LW'(push) - LW'(loadOk);
    end
  end

  // Control state and IR; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      ir_q      <= '0;
      irValid_q <= 1'b0;
      uflow_q   <= 1'b0;
    end else begin
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
      ir_q      <= ir_d;
      irValid_q <= irValid_d;
      uflow_q   <= uflow_d;
    end
  end

  // Queue storage is not reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_in && push) begin
      mem_q[wrPtr_q] <= ins_in;
    end
  end

  assign ins_out      = ir_q;
  assign ir_valid_out = irValid_q;
  assign level_out    = count_q;
  assign uflow_out    = uflow_q;

  // Field decode; full-width fields pass the IR straight through.
  generate
    if (AF_BITS == W) begin : gIaFull
      assign ia_out = ir_q;
    end else begin : gIaPart
      assign ia_out = {{(W-AF_BITS){1'b0}}, ir_q[AF_BITS-1:0]};
    end

    if (IF_BITS == W) begin : gIvFull
      assign iv_out = ir_q;
    end else if (SIGN_EXT) begin : gIvSign
      assign iv_out = {{(W-IF_BITS){ir_q[IF_BITS-1]}}, ir_q[IF_BITS-1:0]};
    end else begin : gIvZero
      assign iv_out = {{(W-IF_BITS){1'b0}}, ir_q[IF_BITS-1:0]};
    end
  endgenerate

endmodule
